// File: rtl/uart_comm_pkg.sv
// Shared definitions for the host-link UART: FSM state encodings and command framing.
package uart_comm_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_XMIT = 1'b1
    } tx_state_e;

    localparam int CMD_BYTES = 3;
    localparam int BYTE_W    = 8;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer plus 8N1 deserializer with glitch rejection on the start bit.
module uart_rx_core
    import uart_comm_pkg::*;
#(
    parameter int CLK_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_rdy,
    output logic       frame_err
);

    localparam int CW = $clog2(CLK_PER_BIT) + 1;
    localparam logic [CW-1:0] BIT_END  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_PER_BIT / 2 - 1);

    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          rdy_q, ferr_q;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rdy_q  <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    // Needs a genuine high-to-low edge, so a line stuck low after a framing error is ignored.
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_END) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BIT_END) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BIT_END) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (rx_sync_q) begin
                            rdy_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_byte   = shift_q;
    assign rx_rdy    = rdy_q;
    assign frame_err = ferr_q;

endmodule

// File: rtl/uart_comm.sv
// Host-link front end: assembles 3-byte host commands from RX and serializes response bytes onto TX.
module uart_comm
    import uart_comm_pkg::*;
#(
    parameter int CLK_PER_BIT = 868,
    parameter int TIMEOUT     = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp_data,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam int BW  = $clog2(CLK_PER_BIT) + 1;
    localparam int TW  = $clog2(TIMEOUT) + 1;
    localparam int SHW = BYTE_W * (CMD_BYTES - 1);
    localparam logic [BW-1:0] BIT_END   = BW'(CLK_PER_BIT - 1);
    localparam logic [TW-1:0] TO_END    = TW'(TIMEOUT - 1);
    localparam logic [1:0]    LAST_BYTE = 2'(CMD_BYTES - 1);

    logic [7:0] rx_byte;
    logic       rx_rdy, frame_err;

    uart_rx_core #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (RX),
        .rx_byte   (rx_byte),
        .rx_rdy    (rx_rdy),
        .frame_err (frame_err)
    );

    logic [1:0]     count_q, count_d;
    logic [SHW-1:0] shadow_q, shadow_d;
    logic [23:0]    cmd_q, cmd_d;
    logic           cmd_rdy_q, cmd_rdy_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;

    always_comb begin
        count_d   = count_q;
        shadow_d  = shadow_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        to_cnt_d  = to_cnt_q;
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        if (frame_err) begin
            count_d  = '0;
            to_cnt_d = '0;
        end else if (rx_rdy) begin
            to_cnt_d = '0;
            if (count_q == LAST_BYTE) begin
                count_d = '0;
                // A release in the same cycle frees the slot, so the new command is kept.
                if (!cmd_rdy_q || clr_cmd_rdy) begin
                    cmd_d     = {shadow_q, rx_byte};
                    cmd_rdy_d = 1'b1;
                end
            end else begin
                shadow_d = {shadow_q[SHW-BYTE_W-1:0], rx_byte};
                count_d  = count_q + 2'd1;
            end
        end else if (count_q != '0) begin
            if (to_cnt_q == TO_END) begin
                count_d  = '0;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            shadow_q  <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            count_q   <= count_d;
            shadow_q  <= shadow_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    tx_state_e     tx_state_q;
    logic [BW-1:0] tx_cnt_q;
    logic [3:0]    tx_bits_q;
    logic [8:0]    tx_shift_q;
    logic          tx_q, resp_sent_q;

    // Start bit is driven directly on accept; the shifter holds the data bits and the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bits_q   <= '0;
            tx_shift_q  <= '1;
            tx_q        <= 1'b1;
            resp_sent_q <= 1'b0;
        end else begin
            resp_sent_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (send_resp) begin
                        tx_shift_q <= {1'b1, resp_data};
                        tx_q       <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_bits_q  <= '0;
                        tx_state_q <= TX_XMIT;
                    end
                end
                TX_XMIT: begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_q <= '0;
                        if (tx_bits_q == 4'd9) begin
                            tx_q        <= 1'b1;
                            resp_sent_q <= 1'b1;
                            tx_state_q  <= TX_IDLE;
                        end else begin
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                            tx_bits_q  <= tx_bits_q + 4'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + BW'(1);
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign TX        = tx_q;
    assign resp_sent = resp_sent_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;

endmodule
